// File: rtl/brc_pkg.sv
// ============================================================================
// Module  : brc_pkg
// Brief   : Shared FSM state type and default sizing for the iterative compare.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package brc_pkg;

  localparam int BRC_WIDTH = 32;
  localparam int BRC_CHUNK = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } brc_state_e;

endpackage

`default_nettype wire

// File: rtl/brc_iter_if.sv
// ============================================================================
// Module  : brc_iter_if
// Brief   : Request/response handshake bundle for the iterative branch compare.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface brc_iter_if #(
  parameter int WIDTH = brc_pkg::BRC_WIDTH
);

  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] rs1;
  logic [WIDTH-1:0] rs2;
  logic             br_un;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             br_less;
  logic             br_equal;

  modport master (
    output req_valid, rs1, rs2, br_un, rsp_ready,
    input  req_ready, rsp_valid, br_less, br_equal
  );

  modport slave (
    input  req_valid, rs1, rs2, br_un, rsp_ready,
    output req_ready, rsp_valid, br_less, br_equal
  );

endinterface

`default_nettype wire

// File: rtl/brc_chunk_cmp.sv
// ============================================================================
// Module  : brc_chunk_cmp
// Brief   : Combinational unsigned equal/less-than compare of one CHUNK slice.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module brc_chunk_cmp #(
  parameter int CHUNK = brc_pkg::BRC_CHUNK
) (
  input  wire logic [CHUNK-1:0] i_a,
  input  wire logic [CHUNK-1:0] i_b,
  output logic                  o_eq,
  output logic                  o_lt
);

  assign o_eq = (i_a == i_b);
  assign o_lt = (i_a <  i_b);

endmodule

`default_nettype wire

// File: rtl/brc_iter.sv
// ============================================================================
// Module  : brc_iter
// Brief   : Multi-cycle branch comparator, one CHUNK slice per cycle, MSB first.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module brc_iter
  import brc_pkg::*;
#(
  parameter int WIDTH = BRC_WIDTH,
  parameter int CHUNK = BRC_CHUNK
) (
  input  wire logic             i_clk,
  input  wire logic             i_reset,
  input  wire logic             i_valid,
  output logic                  o_ready,
  input  wire logic [WIDTH-1:0] i_rs1_data,
  input  wire logic [WIDTH-1:0] i_rs2_data,
  input  wire logic             i_br_un,
  output logic                  o_valid,
  input  wire logic             i_ready,
  output logic                  o_br_less,
  output logic                  o_br_equal
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  brc_state_e        state_q, state_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]  rs1_q, rs1_d;
  logic [WIDTH-1:0]  rs2_q, rs2_d;
  logic              less_q, less_d;
  logic              equal_q, equal_d;

  logic [WIDTH-1:0]  w_flip;
  logic [CHUNK-1:0]  w_a_chunks [NCHUNK];
  logic [CHUNK-1:0]  w_b_chunks [NCHUNK];
  logic [CHUNK-1:0]  w_a_sel;
  logic [CHUNK-1:0]  w_b_sel;
  logic              w_eq;
  logic              w_lt;
  logic              w_last;

  // Signed mode biases both sign bits at latch time so a single unsigned
  // comparator serves both modes.
  assign w_flip = {~i_br_un, {(WIDTH-1){1'b0}}};

  // Chunk 0 is the most significant slice.
  for (genvar gi = 0; gi < NCHUNK; gi++) begin : g_slice
    assign w_a_chunks[gi] = rs1_q[WIDTH-1-gi*CHUNK -: CHUNK];
    assign w_b_chunks[gi] = rs2_q[WIDTH-1-gi*CHUNK -: CHUNK];
  end

  assign w_a_sel = w_a_chunks[idx_q];
  assign w_b_sel = w_b_chunks[idx_q];
  assign w_last  = (idx_q == IDXW'(NCHUNK - 1));

  brc_chunk_cmp #(
    .CHUNK (CHUNK)
  ) u_chunk_cmp (
    .i_a  (w_a_sel),
    .i_b  (w_b_sel),
    .o_eq (w_eq),
    .o_lt (w_lt)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    less_d  = less_q;
    equal_d = equal_q;
    unique case (state_q)
      IDLE: begin
        if (i_valid) begin
          rs1_d   = i_rs1_data ^ w_flip;
          rs2_d   = i_rs2_data ^ w_flip;
          idx_d   = '0;
          state_d = CMP;
        end
      end
      CMP: begin
        if (!w_eq) begin
          less_d  = w_lt;
          equal_d = 1'b0;
          state_d = DONE;
        end else if (w_last) begin
          less_d  = 1'b0;
          equal_d = 1'b1;
          state_d = DONE;
        end else begin
          idx_d = idx_q + IDXW'(1);
        end
      end
      DONE: begin
        if (i_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      less_q  <= 1'b0;
      equal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      less_q  <= less_d;
      equal_q <= equal_d;
    end
  end

  assign o_ready    = (state_q == IDLE);
  assign o_valid    = (state_q == DONE);
  assign o_br_less  = less_q;
  assign o_br_equal = equal_q;

endmodule

`default_nettype wire
